// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive half of the UART. Recovers serial frames from rx,
// queues the received bytes in a small FIFO and exposes them through a
// 4-bit-address register read port (RXDATA at 4'h0, STATUS at 4'h1).
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing with
// a parity-error flag; when it is undefined the frame is 8N1 and the
// parity flag reads 0.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [3:0] addr,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       rx_avail
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Synchroniser and edge-detect history
    logic [1:0]       r_sync;
    logic             r_rs_prev;
    logic             w_rs;

    // Frame recovery
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_push_req;
    logic [7:0]       r_push_data;
    logic             r_frame_set;
    logic             r_parity_set;

    // FIFO and status
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             r_overrun;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             r_rx_avail;
    logic [7:0]       r_data_out;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_stat_rd;
    logic [7:0]       w_status;
    logic [7:0]       w_rd_data;

    assign w_rs      = r_sync[1];
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop     = rd_en && (addr == 4'h0) && !w_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_push    = r_push_req && (!w_full || w_pop);
    assign w_stat_rd = rd_en && (addr == 4'h1);
    assign w_status  = {3'b000, r_parity_err, r_overrun, r_frame_err, w_full, ~w_empty};

    assign data_out  = r_data_out;
    assign rx_avail  = r_rx_avail;

    // Two-flop synchroniser for the asynchronous rx line plus previous sample for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rs_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rs_prev <= w_rs;
        end
    end

    // Frame recovery FSM: start qualification, mid-bit sampling, stop check, break wait
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_push_req   <= 1'b0;
            r_push_data  <= 8'h00;
            r_frame_set  <= 1'b0;
            r_parity_set <= 1'b0;
        end else begin
            r_push_req   <= 1'b0;
            r_frame_set  <= 1'b0;
            r_parity_set <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_rs_prev && !w_rs) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!w_rs) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt        <= '0;
                        r_parity_set <= (^r_shift) ^ w_rs;
                        r_state      <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (w_rs) begin
                            r_push_req  <= 1'b1;
                            r_push_data <= r_shift;
                            r_state     <= S_IDLE;
                        end else begin
                            r_frame_set <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (w_rs) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_BREAK;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // FIFO storage and pointers; overrun drops the new byte and leaves contents intact
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= r_push_data;
                r_wptr                <= r_wptr + PW'(1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end else begin
                r_rptr <= r_rptr;
            end
        end
    end

    // Sticky error flags: cleared by a STATUS read, a same-cycle set takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_overrun   <= (r_push_req && w_full && !w_pop) || (r_overrun && !w_stat_rd);
            r_frame_err <= r_frame_set || (r_frame_err && !w_stat_rd);
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_parity_set || (r_parity_err && !w_stat_rd);
`else
            r_parity_err <= 1'b0;
`endif
        end
    end

    // Read-data mux for the register port
    always_comb begin
        w_rd_data = 8'h00;
        case (addr)
            4'h0: begin
                if (!w_empty) begin
                    w_rd_data = r_mem[r_rptr[AW-1:0]];
                end else begin
                    w_rd_data = 8'h00;
                end
            end
            4'h1:    w_rd_data = w_status;
            default: w_rd_data = 8'h00;
        endcase
    end

    // Registered read data (held while idle) and data-available interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= 8'h00;
            r_rx_avail <= 1'b0;
        end else begin
            if (rd_en) begin
                r_data_out <= w_rd_data;
            end else begin
                r_data_out <= r_data_out;
            end
            r_rx_avail <= !w_empty;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed test of uart_rx_fifo with CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Define UART_RX_PARITY_EN on both files to build the 8E1 variant and its parity test.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [3:0] addr;
    logic       rd_en;
    logic [7:0] data_out;
    logic       rx_avail;

    int n_total;
    int n_bad;
    logic [7:0] rd_v;

    uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .addr     (addr),
        .rd_en    (rd_en),
        .data_out (data_out),
        .rx_avail (rx_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One frame, LSB first; stop_v is the stop-bit level, par_flip inverts the parity bit
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_flip);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (16) @(negedge clk);
`else
        if (par_flip) rx = rx;
`endif
        rx = stop_v;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Register read issued at a falling edge; data sampled at the next falling edge
    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        addr  = 4'h0;
        d     = data_out;
    endtask

    task automatic wait_avail();
        for (int k = 0; k < 40 && !rx_avail; k++) @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst   = 1'b1;
        rx    = 1'b1;
        addr  = 4'h0;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_rx_avail", {7'd0, rx_avail}, 8'h00);

        // 1: single byte round trip
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_avail();
        check("t1_avail", {7'd0, rx_avail}, 8'h01);
        read_reg(4'h0, rd_v);
        check("t1_data", rd_v, 8'hA5);
        @(negedge clk);
        check("t1_avail_after_pop", {7'd0, rx_avail}, 8'h00);
        repeat (3) @(negedge clk);
        check("t1_hold", data_out, 8'hA5);
        read_reg(4'h0, rd_v);
        check("t1_empty_read", rd_v, 8'h00);
        read_reg(4'h7, rd_v);
        check("unmapped_read", rd_v, 8'h00);

        // 2: short glitch is rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        read_reg(4'h1, rd_v);
        check("t2_status", rd_v, 8'h00);

        // 3: framing error, flag cleared by read
        send_byte(8'h3C, 1'b0, 1'b0);
        read_reg(4'h1, rd_v);
        check("t3_status", rd_v, 8'h04);
        read_reg(4'h1, rd_v);
        check("t3_status_clr", rd_v, 8'h00);

        // 4: overrun on the fifth byte
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
        read_reg(4'h1, rd_v);
        check("t4_status", rd_v, 8'h0B);
        for (int i = 1; i <= 4; i++) begin
            read_reg(4'h0, rd_v);
            check("t4_data", rd_v, 8'(i));
        end
        read_reg(4'h0, rd_v);
        check("t4_empty", rd_v, 8'h00);
        @(negedge clk);
        check("t4_avail", {7'd0, rx_avail}, 8'h00);

        // 5: reset in the middle of a frame of 8'hFF
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        send_byte(8'h12, 1'b1, 1'b0);
        wait_avail();
        read_reg(4'h0, rd_v);
        check("t5_data", rd_v, 8'h12);
        read_reg(4'h0, rd_v);
        check("t5_empty", rd_v, 8'h00);
        read_reg(4'h1, rd_v);
        check("t5_status", rd_v, 8'h00);

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch still queues the byte
        send_byte(8'h07, 1'b1, 1'b1);
        wait_avail();
        read_reg(4'h1, rd_v);
        check("t6_status", rd_v, 8'h11);
        read_reg(4'h0, rd_v);
        check("t6_data", rd_v, 8'h07);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
